// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 display slice: the BCD digit type,
// the active-high segment table (a = bit 0) and the all-off / dash codes.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_OFF  = 8'h00;
    localparam logic [7:0] SEG_DASH = 8'h40;

    // Codes 10..15 are not valid BCD and show a dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD-plus-decimal-point to 8-bit active-high segment decoder.
// Bits 6:0 are segments a..g, bit 7 is the decimal point.
module seg7_dec
    import seg7_pkg::*;
(
    input  bcd_t       bcd,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, SEG_TABLE[bcd]};

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment display driver with double-buffered capture.
// A strobe loads the shadow buffer; the shadow is promoted to the display
// buffer only at the scan wrap, so a frame is never torn.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  bcd_vld,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // XOR masks applied at the output registers; they double as the
    // all-off reset values for either display polarity.
    localparam logic [7:0]        SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                wrap;
    logic [4*DIGITS-1:0] shadow_bcd;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pend;
    logic [4*DIGITS-1:0] disp_bcd;
    logic [DIGITS-1:0]   disp_dp;
    bcd_t                cur_bcd;
    logic                cur_dp;
    logic [7:0]          dec_seg;
    logic                lzb_blank;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    assign tick = (pcnt == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // Slot prescaler and scan index; the index steps once per slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Shadow capture; a strobe coinciding with the wrap keeps pend set so
    // the new value is promoted at the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            pend       <= 1'b0;
        end else if (bcd_vld) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
            pend       <= 1'b1;
        end else if (wrap) begin
            pend       <= 1'b0;
        end
    end

    // Display buffer is only ever replaced at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else if (wrap && pend) begin
            disp_bcd <= shadow_bcd;
            disp_dp  <= shadow_dp;
        end
    end

    // Select the digit currently being scanned.
    always_comb begin
        cur_bcd = disp_bcd[4*idx +: 4];
        cur_dp  = disp_dp[idx];
    end

    seg7_dec u_dec (
        .bcd (cur_bcd),
        .dp  (cur_dp),
        .seg (dec_seg)
    );

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] blank_mask;
    logic              above_nz;

    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 always shows. Codes 10..15 are non-zero here.
    always_comb begin
        blank_mask = '0;
        above_nz   = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                above_nz = 1'b1;
            end
            blank_mask[i] = !above_nz;
        end
    end

    assign lzb_blank = blank_mask[idx];
`else
    assign lzb_blank = 1'b0;
`endif

    // Next segment/anode pattern; the first cycle of every slot is dark
    // to hide ghosting while the anode switches.
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = '0;
        if (pcnt != '0) begin
            an_next[idx] = 1'b1;
            if (lzb_blank) begin
                seg_next = {cur_dp, 7'b0};
            end else begin
                seg_next = dec_seg;
            end
        end
    end

    // Registered outputs with polarity applied; frame marks the wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= SEG_POL;
            an    <= AN_POL;
            frame <= 1'b0;
        end else begin
            seg   <= seg_next ^ SEG_POL;
            an    <= an_next ^ AN_POL;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=4, active-high).
// A frame-position reference model predicts seg/an/frame every cycle.
module tb_seg7_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        bcd_vld;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int vectorCount;
    int missCount;

    // Reference state: what the shadow and display hold, and edges since reset.
    logic [15:0] mShadow;
    logic [3:0]  mShadowDp;
    bit          mPend;
    logic [15:0] mDisp;
    logic [3:0]  mDispDp;
    int          cyc;

    logic [7:0] refTable [16];

    seg7_scan #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .ACTIVE_LOW (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .bcd_vld (bcd_vld),
        .seg     (seg),
        .an      (an),
        .frame   (frame)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic modelClear();
        mShadow   = '0;
        mShadowDp = '0;
        mPend     = 0;
        mDisp     = '0;
        mDispDp   = '0;
        cyc       = 0;
    endtask

    // Drive one cycle of inputs, predict the registered outputs, check them.
    task automatic applyStimulus(input bit vld, input logic [15:0] bcd, input logic [3:0] dp);
        int         pos;
        int         pc;
        int         id;
        logic [3:0] dig;
        bit         blank;
        logic [7:0] expSeg;
        logic [3:0] expAn;
        bit         expFrame;
        bcd_vld = vld;
        bcd_in  = bcd;
        dp_in   = dp;
        pos = cyc % FRAME;
        pc  = pos % SCAN_DIV;
        id  = pos / SCAN_DIV;
        dig = 4'((mDisp >> (4 * id)) & 16'hF);
        blank = 0;
`ifdef SEG7_LZB_EN
        blank = (id > 0) && ((mDisp >> (4 * id)) == 16'h0);
`endif
        if (pc == 0) begin
            expSeg = 8'h00;
            expAn  = 4'b0000;
        end else begin
            expAn  = 4'(1 << id);
            expSeg = blank ? {mDispDp[id], 7'b0} : ({mDispDp[id], 7'b0} | refTable[dig]);
        end
        expFrame = (pos == FRAME - 1);
        if (pos == FRAME - 1 && mPend) begin
            mDisp   = mShadow;
            mDispDp = mShadowDp;
        end
        if (vld) begin
            mShadow   = bcd;
            mShadowDp = dp;
            mPend     = 1;
        end else if (pos == FRAME - 1) begin
            mPend = 0;
        end
        @(posedge clk);
        #1;
        checkOutput("seg", 32'(seg), 32'(expSeg));
        checkOutput("an", 32'(an), 32'(expAn));
        checkOutput("frame", 32'(frame), 32'(expFrame));
        cyc++;
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 16'($urandom), 4'($urandom));
        end
    endtask

    task automatic alignTo(input int pos);
        for (int k = 0; k < FRAME && (cyc % FRAME) != pos; k++) begin
            runIdle(1);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic doReset();
        bcd_vld = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_seg", 32'(seg), 32'h00);
        checkOutput("rst_an", 32'(an), 32'h0);
        checkOutput("rst_frame", 32'(frame), 32'h0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        modelClear();
    endtask

    initial begin
        refTable = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                     8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        vectorCount = 0;
        missCount   = 0;
        rst     = 1'b1;
        bcd_in  = '0;
        dp_in   = '0;
        bcd_vld = 1'b0;
        modelClear();
        doReset();
        $display("[TB] reset and start-up scan");
        runIdle(6);

        $display("[TB] basic scan 1234");
        applyStimulus(1, 16'h1234, 4'b0000);
        runIdle(3 * FRAME);

        $display("[TB] tear-free capture 5678 during idx 1");
        alignTo(5);
        applyStimulus(1, 16'h5678, 4'b0000);
        runIdle(2 * FRAME);

        $display("[TB] strobe on the wrap edge");
        alignTo(6);
        applyStimulus(1, 16'h4321, 4'b0001);
        alignTo(FRAME - 1);
        applyStimulus(1, 16'h9999, 4'b0000);
        runIdle(3 * FRAME);

        $display("[TB] invalid digits and decimal point");
        applyStimulus(1, 16'hA000, 4'b0100);
        runIdle(2 * FRAME + 3);

`ifdef SEG7_LZB_EN
        $display("[TB] leading-zero blanking");
        applyStimulus(1, 16'h0070, 4'b0000);
        runIdle(2 * FRAME);
        applyStimulus(1, 16'h0000, 4'b0000);
        runIdle(2 * FRAME);
`endif

        $display("[TB] random strobes");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(7) == 0, 16'($urandom), 4'($urandom));
        end

        $display("[TB] reset mid-frame");
        doReset();
        runIdle(2 * FRAME);
        for (int k = 0; k < 100; k++) begin
            applyStimulus($urandom_range(5) == 0, 16'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Downstream display stage for the `cnt10` BCD counter chain. It captures a packed vector of BCD digits on a strobe and drives a common-cathode/anode 7-segment display by time-multiplexing one digit per scan slot. Capture is double-buffered so that a counter update can never tear a frame. Sits between the counter cascade (`dout`/`cout`) and the board display pins.

## Interface
- `DIGITS`, 4: number of display digits; scan index range 0..DIGITS-1, where digit 0 is least significant.
- `SCAN_DIV`, 1000: clocks per digit slot; minimum 2.
- `ACTIVE_LOW`, 0: 1 inverts `seg` and `an` at the output registers.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `bcd_in`  in  4*DIGITS  packed digits; `[3:0]` is digit 0.
- `dp_in`  in  DIGITS  decimal-point request per digit.
- `bcd_vld`  in  1  capture strobe, typically counter `cout` or enable.
- `seg`  out  8  `seg[0..6]` = a..g, `seg[7]` = dp.
- `an`  out  DIGITS  one-hot digit enable.
- `frame`  out  1  one-cycle pulse at each scan wrap.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (`pcnt` == SCAN_DIV-1).
- Scan index `idx` advances on `tick`, wrapping from DIGITS-1 to 0.
- Shadow register: on `bcd_vld`, latch `bcd_in` and `dp_in` into the shadow and set `pend`.
- Display register: on `tick` with `idx` == DIGITS-1 (the wrap), if `pend` is set, copy shadow to display and clear `pend`.
- Simultaneous `bcd_vld` and wrap: the display takes the old shadow, the shadow takes the new value, and `pend` stays 1. The new value shows in the following frame.
- Decode of the display digit at `idx` (active-high form, a=bit0), given in hex:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66
  - 5→6D, 6→7D, 7→07, 8→7F, 9→6F
  - 10..15→40 (dash).
  - `seg[7]` = display dp bit.
- `an` = one-hot(`idx`), except all-off during the first cycle of each slot (`pcnt` == 0). This anti-ghost blank also forces `seg` to off.
- `ACTIVE_LOW` applies a final XOR on `seg` and `an` only.
- Reset: `pcnt`=0, `idx`=0, `pend`=0, shadow=0, display=0, `frame`=0. `seg` and `an` are all-off, meaning 0 when `ACTIVE_LOW`=0 and all-ones when it is 1.
- Reset mid-frame: all state returns to the values above immediately. Scanning restarts at digit 0 and slot cycle 0 after release.

## Timing
- All outputs are registered, with a 1-cycle latency from `idx`/`pcnt`/display state to `seg`/`an`.
- `frame` is high in the cycle after the wrap edge, for exactly 1 cycle per DIGITS*SCAN_DIV clocks.
- Capture latency: `bcd_vld` sampled at edge N becomes visible no later than the first wrap after N, plus 1 cycle.
- Full frame period: DIGITS*SCAN_DIV clocks.
- Duty per digit: (SCAN_DIV-1)/SCAN_DIV of its slot.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Any display digit above the highest non-zero digit outputs all-off segments, dp included unless that digit's dp bit is set. `an` still scans normally.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - Invalid codes (10..15) count as non-zero.
- `SEG7_LZB_EN` undefined: all digits decode normally, including leading zeros.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16-entry segment constant table;
  - `SEG_OFF` and `SEG_DASH` constants;
  - the `bcd_t` 4-bit typedef.
- One sub-module, `seg7_dec`: combinational BCD-plus-dp to 8-bit segment decoder, instantiated once on the muxed digit.
- Prescaler, scan index, buffers, and output registers live in `seg7_scan`.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4.
- **Reset:** assert `rst` for 3 cycles mid-slot → `seg`=00 and `an`=0000 immediately. After release, the first non-blank `an`=0001 appears at cycle 2.
- **Basic scan:** `bcd_in`=16'h1234 with one `bcd_vld` pulse → from the next frame, slots show `an`=0001/`seg`=66, 0010/4F, 0100/5B, 1000/06. `frame` pulses every 16 cycles.
- **Tear-free capture:** pulse `bcd_vld` with 16'h5678 while `idx`=1 → the rest of the current frame still shows the old digits, and the next frame shows all new digits.
- **Simultaneous strobe and wrap:** pulse `bcd_vld` with 16'h9999 exactly on the wrap edge → the next frame shows the prior shadow, and the frame after that shows 9999 (`seg`=6F).
- **Invalid digits and dp:** `bcd_in`=16'hA000, `dp_in`=4'b0100 → digit 3 `seg`=40, digit 2 `seg`=BF, digits 1 and 0 `seg`=3F.
- **With `SEG7_LZB_EN`:** 16'h0070 → digits 3 and 2 `seg`=00, digit 1 `seg`=07, digit 0 `seg`=3F. Then 16'h0000 → only digit 0 shows 3F.
